output_arbiter: RTL and testbench

OUTPUT_ARBITER -- requirements
Module: output_arbiter

---
 rtl/output_arbiter.sv | 142 ++++++++++++++
 tb/tb_output_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/output_arbiter.sv
// Round-robin output-port arbiter: locks the output to one input port for a whole packet.
// Define OUTPUT_REGISTER_EN to register flit_out/flit_out_valid (one cycle latency).
module output_arbiter #(
  parameter int flit_size   = 4,
  parameter int packet_size = 32,
  parameter int PORTS       = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PORTS-1:0]           request,
  input  logic [PORTS*flit_size-1:0] flit_in,
  input  logic [PORTS-1:0]           flit_valid_in,
  input  logic                       space_available,
  output logic [PORTS-1:0]           stall,
  output logic [PORTS-1:0]           grant,
  output logic [flit_size-1:0]       flit_out,
  output logic                       flit_out_valid
);

  localparam int FLIT_NUMBER = packet_size / flit_size;
  localparam int CW = $clog2(FLIT_NUMBER + 1);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CW-1:0] LAST_M1  = CW'(FLIT_NUMBER - 1);
  localparam logic [PW-1:0] TOP_IDX  = PW'(PORTS - 1);
  localparam logic [PORTS-1:0] ONE_P = {{(PORTS-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    gidx_q, gidx_d;

  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [flit_size-1:0] sel_flit;
  logic                 sel_vld;
  logic                 accept;

  // Search upward from rr_ptr with wrap-around; first requester wins.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < PORTS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= PORTS) cand = cand - PORTS;
      if (!win_found && request[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_flit = '0;
    sel_vld  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (gidx_q == PW'(i)) begin
        sel_flit = flit_in[i*flit_size +: flit_size];
        sel_vld  = flit_valid_in[i];
      end
    end
  end

  assign accept = (state_q == BUSY) && sel_vld;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    if (state_q == IDLE) begin
      if (win_found && space_available) begin
        state_d = BUSY;
        grant_d = ONE_P << win_idx;
        gidx_d  = win_idx;
      end
    end else if (accept) begin
      if (cnt_q == LAST_M1) begin
        // Last flit: release and move the pointer past the port just served.
        state_d  = IDLE;
        grant_d  = '0;
        cnt_d    = '0;
        rr_ptr_d = (gidx_q == TOP_IDX) ? '0 : gidx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
    end
  end

  assign grant = grant_q;
  assign stall = (state_q == BUSY) ? ~grant_q : '1;

`ifdef OUTPUT_REGISTER_EN
  logic [flit_size-1:0] flit_out_q, flit_out_d;
  logic                 flit_out_valid_q, flit_out_valid_d;

  always_comb begin
    flit_out_valid_d = accept;
    flit_out_d       = accept ? sel_flit : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_out_q       <= '0;
      flit_out_valid_q <= 1'b0;
    end else begin
      flit_out_q       <= flit_out_d;
      flit_out_valid_q <= flit_out_valid_d;
    end
  end

  assign flit_out       = flit_out_q;
  assign flit_out_valid = flit_out_valid_q;
`else
  assign flit_out       = accept ? sel_flit : '0;
  assign flit_out_valid = accept;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Directed self-checking bench for output_arbiter (default 5 ports, 4-bit flits, 8 flits/packet).
module tb_output_arbiter;

  logic        clk;
  logic        reset;
  logic [4:0]  request;
  logic [19:0] flit_in;
  logic [4:0]  flit_valid_in;
  logic        space_available;
  logic [4:0]  stall;
  logic [4:0]  grant;
  logic [3:0]  flit_out;
  logic        flit_out_valid;

  int passed;
  int total;

  output_arbiter #(.flit_size(4), .packet_size(32), .PORTS(5)) dut (
    .clk(clk),
    .reset(reset),
    .request(request),
    .flit_in(flit_in),
    .flit_valid_in(flit_valid_in),
    .space_available(space_available),
    .stall(stall),
    .grant(grant),
    .flit_out(flit_out),
    .flit_out_valid(flit_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle for owner port p; every other port drives valid noise flits.
  task automatic flit(input int p, input logic [3:0] v, input logic en);
    for (int q = 0; q < 5; q++) flit_in[q*4 +: 4] = (q == p) ? v : 4'(4'hF ^ q);
    flit_valid_in = en ? 5'h1F : (5'h1F & ~(5'b1 << p));
`ifndef OUTPUT_REGISTER_EN
    #1;
    check("flit_out_valid", {31'b0, flit_out_valid}, {31'b0, en});
    check("flit_out", {28'b0, flit_out}, en ? {28'b0, v} : 32'h0);
    tick();
`else
    tick();
    check("flit_out_valid", {31'b0, flit_out_valid}, {31'b0, en});
    check("flit_out", {28'b0, flit_out}, en ? {28'b0, v} : 32'h0);
`endif
    flit_valid_in = 5'h0;
  endtask

  task automatic packet(input int p, input logic [3:0] base);
    for (int i = 0; i < 8; i++) begin
      flit(p, 4'(base + i), 1'b1);
      if (i == 6) check("grant_hold", {27'b0, grant}, {27'b0, 5'b1 << p});
    end
    check("grant_release", {27'b0, grant}, 32'h0);
    check("stall_release", {27'b0, stall}, 32'h1F);
  endtask

  initial begin
    passed          = 0;
    total           = 0;
    reset           = 1'b0;
    request         = 5'b0;
    flit_in         = 20'h0;
    flit_valid_in   = 5'b0;
    space_available = 1'b0;
    #12;
    check("rst_grant", {27'b0, grant}, 32'h0);
    check("rst_stall", {27'b0, stall}, 32'h1F);
    check("rst_fov", {31'b0, flit_out_valid}, 32'h0);
    check("rst_fout", {28'b0, flit_out}, 32'h0);
    reset = 1'b1;
    tick();

    // Port 2 alone, flits 1..8
    request         = 5'b00100;
    space_available = 1'b1;
    tick();
    check("p2_grant", {27'b0, grant}, 32'h04);
    check("p2_stall", {27'b0, stall}, 32'h1B);
    request = 5'b0;
    packet(2, 4'h1);

    // Pointer now 3: ports 0 and 4 request, 4 wins after one idle cycle
    request = 5'b10001;
    #1;
    check("gap_idle", {27'b0, grant}, 32'h0);
    tick();
    check("ptr3_grant", {27'b0, grant}, 32'h10);
    request = 5'b0;
    packet(4, 4'h3);

    // Ports 0,1,4 request with pointer 0; port 0 keeps requesting past release
    request = 5'b10011;
    tick();
    check("rr_g0", {27'b0, grant}, 32'h01);
    packet(0, 4'h8);
    tick();
    check("rr_g1", {27'b0, grant}, 32'h02);
    request = 5'b10001;
    packet(1, 4'hA);
    tick();
    check("rr_g4", {27'b0, grant}, 32'h10);
    request = 5'b0;
    packet(4, 4'h5);

    // Port 3 waits on space_available for 5 cycles
    request         = 5'b01000;
    space_available = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nospace_grant", {27'b0, grant}, 32'h0);
      check("nospace_stall", {27'b0, stall}, 32'h1F);
    end
    space_available = 1'b1;
    tick();
    check("space_grant", {27'b0, grant}, 32'h08);
    request = 5'b0;
    packet(3, 4'h2);

    // Port 1 with a 2-cycle hole while port 0 drives valid flits
    request = 5'b00010;
    tick();
    check("hole_grant", {27'b0, grant}, 32'h02);
    request = 5'b0;
    for (int i = 0; i < 3; i++) flit(1, 4'(4'h4 + i), 1'b1);
    flit(1, 4'h0, 1'b0);
    flit(1, 4'h0, 1'b0);
    for (int i = 3; i < 8; i++) begin
      flit(1, 4'(4'h4 + i), 1'b1);
      if (i == 6) check("hole_hold", {27'b0, grant}, 32'h02);
    end
    check("hole_release", {27'b0, grant}, 32'h0);

    // Reset mid-packet after 3 flits of port 2
    request = 5'b00100;
    tick();
    check("mid_grant", {27'b0, grant}, 32'h04);
    request = 5'b0;
    for (int i = 0; i < 3; i++) flit(2, 4'(4'h9 + i), 1'b1);
    flit_in[8 +: 4] = 4'hC;
    flit_valid_in   = 5'b00100;
    #2;
    reset = 1'b0;
    #1;
    check("abort_grant", {27'b0, grant}, 32'h0);
    check("abort_stall", {27'b0, stall}, 32'h1F);
    check("abort_fov", {31'b0, flit_out_valid}, 32'h0);
    #3;
    reset   = 1'b1;
    request = 5'b01010;
    #1;
    check("post_rst_grant", {27'b0, grant}, 32'h0);
    tick();
    check("post_rst_lowest", {27'b0, grant}, 32'h02);
    check("post_rst_fov", {31'b0, flit_out_valid}, 32'h0);
    request       = 5'b0;
    flit_valid_in = 5'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
